// File: rtl/isp_pkg.sv
// Shared constants, state encoding and address helper for the ISP DRAM scheduler.
package isp_pkg;

    localparam logic [3:0]  AXI_ID         = 4'd0;
    localparam logic [2:0]  AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [31:0] DRAM_BASE      = 32'h0001_0000;
    localparam logic [31:0] DRAM_PIC_BYTES = 32'd3072;
    localparam int          CID_W          = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_XFER,
        ST_RESP
    } sched_state_t;

    // Picture base address; wraps silently at 32 bits.
    function automatic logic [31:0] pic_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [3:0]  pic);
        return base + stride * {28'd0, pic};
    endfunction

endpackage

// File: rtl/isp_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the last client served.
module isp_rr_arb2
    import isp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       i_req,
    input  logic             i_upd,
    input  logic [CID_W-1:0] i_upd_id,
    output logic             o_any,
    output logic [CID_W-1:0] o_gnt
);

    logic [CID_W-1:0] r_ptr;

    // Pointer starts at 1 so client 0 wins the first contested round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b1;
        end else if (i_upd) begin
            r_ptr <= i_upd_id;
        end
    end

    always_comb begin
        o_any = |i_req;
        o_gnt = 1'b0;
        if (&i_req) begin
            o_gnt = ~r_ptr;
        end else if (i_req[1]) begin
            o_gnt = 1'b1;
        end
    end

endmodule

// File: rtl/isp_dram_sched.sv
// Shares one AXI4 DRAM port between the exposure (0) and focus/crop (1) clients,
// one read burst plus optional same-address write-back per transaction.
module isp_dram_sched
    import isp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DRAM_BASE,
    parameter logic [31:0] PIC_BYTES = DRAM_PIC_BYTES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [7:0]       req_pic_no,
    input  logic [15:0]      req_len,
    input  logic [1:0]       req_wb,
    output logic [CID_W-1:0] gnt_id,
    output logic             busy,
    output logic             rd_beat_valid,
    output logic [127:0]     rd_beat_data,
    output logic             rd_beat_last,
    input  logic             rd_beat_ready,
    input  logic             wr_beat_valid,
    input  logic [127:0]     wr_beat_data,
    output logic             wr_beat_ready,
    output logic             done_valid,
    output logic [CID_W-1:0] done_id,
    output logic             done_err,
    output logic [3:0]       arid,
    output logic [31:0]      araddr,
    output logic [7:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    output logic             arvalid,
    input  logic             arready,
    input  logic [127:0]     rdata,
    input  logic [1:0]       rresp,
    input  logic             rlast,
    input  logic             rvalid,
    output logic             rready,
    output logic [3:0]       awid,
    output logic [31:0]      awaddr,
    output logic [7:0]       awlen,
    output logic [2:0]       awsize,
    output logic [1:0]       awburst,
    output logic             awvalid,
    input  logic             awready,
    output logic [127:0]     wdata,
    output logic [15:0]      wstrb,
    output logic             wlast,
    output logic             wvalid,
    input  logic             wready,
    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             bready
);

    sched_state_t     r_state, w_next;
    logic [CID_W-1:0] r_gnt;
    logic [7:0]       r_len, r_rcnt, r_wcnt, r_arlen, r_awlen;
    logic [31:0]      r_araddr, r_awaddr;
    logic             r_wb, r_err, r_rdone, r_wdone, r_bdone, r_arvalid, r_awvalid;

    logic             w_any, w_grant, w_rd_act, w_wr_act;
    logic             w_r_hs, w_w_hs, w_b_hs, w_r_final, w_w_final;
    logic [CID_W-1:0] w_arb_gnt;
    logic [3:0]       w_sel_pic;
    logic [7:0]       w_sel_len;
    logic             w_sel_wb;

    isp_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (req_valid),
        .i_upd    (done_valid),
        .i_upd_id (r_gnt),
        .o_any    (w_any),
        .o_gnt    (w_arb_gnt)
    );

    assign w_sel_pic = w_arb_gnt ? req_pic_no[7:4] : req_pic_no[3:0];
    assign w_sel_len = w_arb_gnt ? req_len[15:8]   : req_len[7:0];
    assign w_sel_wb  = req_wb[w_arb_gnt];
    assign w_grant   = (r_state == ST_IDLE) && w_any;
    assign req_ready = w_grant ? (w_arb_gnt ? 2'b10 : 2'b01) : 2'b00;

    // Data streams pass straight through; only the handshakes are gated by phase.
    assign w_rd_act      = (r_state == ST_XFER) && !r_rdone;
    assign w_wr_act      = (r_state == ST_XFER) && r_wb && !r_wdone;
    assign rready        = w_rd_act && rd_beat_ready;
    assign rd_beat_valid = w_rd_act && rvalid;
    assign rd_beat_data  = rdata;
    assign rd_beat_last  = w_rd_act && rlast;
    assign wvalid        = w_wr_act && wr_beat_valid;
    assign wr_beat_ready = w_wr_act && wready;
    assign wdata         = wr_beat_data;
    assign wstrb         = '1;
    assign wlast         = w_wr_act && (r_wcnt == r_len);
    assign bready        = (r_state == ST_RESP) && r_wb && !r_bdone;

    assign w_r_hs    = rvalid && rready;
    assign w_w_hs    = wvalid && wready;
    assign w_b_hs    = bvalid && bready;
    assign w_r_final = w_r_hs && (r_rcnt == r_len);
    assign w_w_final = w_w_hs && (r_wcnt == r_len);

    assign done_valid = (r_state == ST_RESP) && (!r_wb || r_bdone);
    assign done_id    = r_gnt;
    assign done_err   = r_err;
    assign gnt_id     = r_gnt;
    assign busy       = (r_state != ST_IDLE);

    assign arid    = AXI_ID;
    assign arsize  = AXI_SIZE_16B;
    assign arburst = AXI_BURST_INCR;
    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arvalid = r_arvalid;
    assign awid    = AXI_ID;
    assign awsize  = AXI_SIZE_16B;
    assign awburst = AXI_BURST_INCR;
    assign awaddr  = r_awaddr;
    assign awlen   = r_awlen;
    assign awvalid = r_awvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_next = ST_ADDR;
            ST_ADDR: if ((!r_arvalid || arready) && (!r_awvalid || awready)) w_next = ST_XFER;
            ST_XFER: if ((r_rdone || w_r_final) && (!r_wb || r_wdone || w_w_final)) w_next = ST_RESP;
            ST_RESP: if (done_valid) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt     <= '0;
            r_len     <= '0;
            r_rcnt    <= '0;
            r_wcnt    <= '0;
            r_arlen   <= '0;
            r_awlen   <= '0;
            r_araddr  <= '0;
            r_awaddr  <= '0;
            r_wb      <= 1'b0;
            r_err     <= 1'b0;
            r_rdone   <= 1'b0;
            r_wdone   <= 1'b0;
            r_bdone   <= 1'b0;
            r_arvalid <= 1'b0;
            r_awvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_any) begin
                    r_gnt     <= w_arb_gnt;
                    r_len     <= w_sel_len;
                    r_wb      <= w_sel_wb;
                    r_err     <= 1'b0;
                    r_rcnt    <= '0;
                    r_wcnt    <= '0;
                    r_rdone   <= 1'b0;
                    r_wdone   <= 1'b0;
                    r_bdone   <= 1'b0;
                    r_araddr  <= pic_addr(BASE_ADDR, PIC_BYTES, w_sel_pic);
                    r_arlen   <= w_sel_len;
                    r_arvalid <= 1'b1;
                    if (w_sel_wb) begin
                        r_awaddr  <= pic_addr(BASE_ADDR, PIC_BYTES, w_sel_pic);
                        r_awlen   <= w_sel_len;
                        r_awvalid <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (arready) r_arvalid <= 1'b0;
                    if (awready) r_awvalid <= 1'b0;
                end
                ST_XFER: begin
                    // rlast must coincide exactly with beat number len.
                    if (w_r_hs) begin
                        r_rcnt <= r_rcnt + 8'd1;
                        if ((rresp != 2'b00) || (rlast != (r_rcnt == r_len))) r_err <= 1'b1;
                        if (r_rcnt == r_len) r_rdone <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wcnt <= r_wcnt + 8'd1;
                        if (r_wcnt == r_len) r_wdone <= 1'b1;
                    end
                end
                ST_RESP: if (w_b_hs) begin
                    r_bdone <= 1'b1;
                    if (bresp != 2'b00) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_isp_dram_sched.sv
// Directed bench for isp_dram_sched: AXI slave/client models plus a done-pulse scoreboard.
module tb_isp_dram_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid, req_ready, req_wb;
    logic [7:0]   req_pic_no;
    logic [15:0]  req_len;
    logic         gnt_id, busy;
    logic         rd_beat_valid, rd_beat_last, rd_beat_ready;
    logic [127:0] rd_beat_data, wr_beat_data, rdata, wdata;
    logic         wr_beat_valid, wr_beat_ready;
    logic         done_valid, done_id, done_err;
    logic [3:0]   arid, awid;
    logic [31:0]  araddr, awaddr;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst, rresp, bresp;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [15:0]  wstrb;

    always #5 clk = ~clk;

    isp_dram_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_pic_no(req_pic_no),
        .req_len(req_len), .req_wb(req_wb), .gnt_id(gnt_id), .busy(busy),
        .rd_beat_valid(rd_beat_valid), .rd_beat_data(rd_beat_data),
        .rd_beat_last(rd_beat_last), .rd_beat_ready(rd_beat_ready),
        .wr_beat_valid(wr_beat_valid), .wr_beat_data(wr_beat_data),
        .wr_beat_ready(wr_beat_ready),
        .done_valid(done_valid), .done_id(done_id), .done_err(done_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic       id;
        logic       err;
        logic       wb;
        logic [7:0] len;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0, bad = 0, cyc = 0;
    int          n_done = 0, n_want = 0;
    logic [31:0] e_addr = '0;
    logic [7:0]  e_len = '0;
    bit          e_wb = 0, e_toggle = 0;
    int          e_rerr_beat = -1;
    logic [1:0]  e_bresp = 2'b00;

    int rd_cnt = 0, r_n = 0, r_tot = 0, wn = 0, aw_wait = 0, b_wait = 0;
    int last_rd_cyc = 0, b_cyc = 0;
    bit r_act = 0, r_start = 0, aw_done = 0, b_seen = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] rpat(input logic [31:0] addr, input int n);
        return {addr, 64'hA5A5_1234_0000_0000, 32'(n)};
    endfunction

    function automatic logic [127:0] wpat(input int n);
        return {32'hC0DE_0000, 64'h5A5A_0000_9876_0000, 32'(n)};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // AXI slave and client stream models: sample at negedge, drive just after posedge.
    initial begin
        arready = 1'b1; awready = 1'b0; wready = 1'b1;
        rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
        bvalid = 1'b0; bresp = 2'b00;
        rd_beat_ready = 1'b1; wr_beat_valid = 1'b0; wr_beat_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (arvalid && arready) begin
                    chk("araddr", araddr, e_addr);
                    chk("arlen", arlen, e_len);
                    chk("aw_with_ar", awvalid, e_wb);
                    chk("arsize", arsize, 3'b100);
                    chk("arburst", arburst, 2'b01);
                    r_start = 1; rd_cnt = 0; wn = 0; aw_done = 0; b_seen = 0; b_wait = 0;
                end
                if (awvalid && awready) begin
                    chk("awaddr", awaddr, e_addr);
                    chk("awlen", awlen, e_len);
                    aw_done = 1; aw_wait = 0;
                end else if (awvalid) begin
                    aw_wait++;
                end
                if (wvalid && !aw_done) chk("w_before_aw", wvalid, 1'b0);
                if (rvalid && rready) r_n++;
                if (e_toggle && rvalid) chk("rready_track", rready, rd_beat_ready);
                if (rd_beat_valid && rd_beat_ready) begin
                    chk("rd_data", rd_beat_data, rpat(e_addr, rd_cnt));
                    chk("rd_last", rd_beat_last, rd_cnt == int'(e_len));
                    rd_cnt++;
                    last_rd_cyc = cyc;
                end
                if (wvalid && wready) begin
                    chk("wdata", wdata, wpat(wn));
                    chk("wlast", wlast, wn == int'(e_len));
                    wn++;
                end
                if (bvalid && bready) begin
                    b_seen = 1;
                    b_cyc = cyc;
                end
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                r_act = 0; r_start = 0; r_n = 0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                awready = 1'b0; aw_wait = 0; bvalid = 1'b0; b_wait = 0;
                rd_beat_ready = 1'b1; wr_beat_valid = 1'b0;
            end else begin
                if (r_start) begin
                    r_act = 1; r_n = 0; r_tot = int'(e_len) + 1; r_start = 0;
                end
                if (r_act && r_n == r_tot) r_act = 0;
                rvalid = r_act;
                rdata  = rpat(e_addr, r_n);
                rlast  = r_act && (r_n == r_tot - 1);
                rresp  = (r_act && r_n == e_rerr_beat) ? 2'b10 : 2'b00;
                awready = (aw_wait >= 2);
                wr_beat_valid = e_wb && (cyc % 3 != 2);
                wr_beat_data  = wpat(wn);
                if (bvalid && b_seen) begin
                    bvalid = 1'b0;
                end else if (e_wb && !b_seen && wn == int'(e_len) + 1) begin
                    if (b_wait >= 3) bvalid = 1'b1;
                    else b_wait++;
                end
                bresp = e_bresp;
                rd_beat_ready = e_toggle ? ~rd_beat_ready : 1'b1;
            end
        end
    end

    // Scoreboard monitor: each done pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got id %0d err %0d, expected none", done_id, done_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_id", done_id, e.id);
                    chk("done_err", done_err, e.err);
                    chk("rd_beats", rd_cnt, int'(e.len) + 1);
                    if (e.wb) begin
                        chk("w_beats", wn, int'(e.len) + 1);
                        chk("b_seen", b_seen, 1'b1);
                        chk("done_after_b", cyc, b_cyc + 1);
                        chk("bready_low", bready, 1'b0);
                    end else begin
                        chk("done_latency", cyc, last_rd_cyc + 1);
                    end
                end
                n_done++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_txn(input bit c, input logic [31:0] addr, input logic [7:0] len,
                              input bit wb, input bit tog, input int rerr,
                              input logic [1:0] br, input bit err);
        exp_t e;
        e_addr = addr; e_len = len; e_wb = wb; e_toggle = tog;
        e_rerr_beat = rerr; e_bresp = br;
        e.id = c; e.err = err; e.wb = wb; e.len = len;
        exp_q.push_back(e);
        n_want++;
    endtask

    task automatic issue(input bit c, input logic [3:0] pic, input logic [7:0] len, input bit wb);
        req_valid[c] = 1'b1;
        req_wb[c]    = wb;
        if (c) begin
            req_pic_no[7:4] = pic; req_len[15:8] = len;
        end else begin
            req_pic_no[3:0] = pic; req_len[7:0] = len;
        end
    endtask

    task automatic wait_grant(input bit c);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) got = 1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL grant_timeout: got no req_ready, expected client %0d", c);
        end else begin
            chk("req_ready", req_ready, c ? 2'b10 : 2'b01);
        end
        @(posedge clk);
        #1;
        req_valid[c] = 1'b0;
        req_wb[c]    = 1'b0;
        @(negedge clk);
        chk("gnt_id", gnt_id, c);
        chk("req_ready_pulse", req_ready, 2'b00);
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(posedge clk);
            #1;
            if (n_done >= n_want) got = 1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL done_timeout: got %0d completions, expected %0d", n_done, n_want);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; req_wb = 2'b00; req_pic_no = '0; req_len = '0;
        tick(3);
        chk("rst_busy", busy, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_wlast", wlast, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_done", done_valid, 1'b0);
        chk("rst_gnt", gnt_id, 1'b0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_arlen", arlen, 8'h0);
        rst_n = 1'b1;
        tick(2);

        // Plain read, pic 3, 192 beats.
        expect_txn(1'b0, 32'h0001_2400, 8'd191, 1'b0, 1'b0, -1, 2'b00, 1'b0);
        issue(1'b0, 4'd3, 8'd191, 1'b0);
        wait_grant(1'b0);
        wait_done();

        // Read plus write-back, pic 15, 192 beats each, W bubbles.
        expect_txn(1'b0, 32'h0001_B400, 8'd191, 1'b1, 1'b0, -1, 2'b00, 1'b0);
        issue(1'b0, 4'd15, 8'd191, 1'b1);
        wait_grant(1'b0);
        wait_done();

        // Round-robin from a fresh reset.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        expect_txn(1'b0, 32'h0001_0C00, 8'd3, 1'b0, 1'b0, -1, 2'b00, 1'b0);
        issue(1'b0, 4'd1, 8'd3, 1'b0);
        issue(1'b1, 4'd2, 8'd3, 1'b0);
        wait_grant(1'b0);
        wait_done();
        expect_txn(1'b1, 32'h0001_1800, 8'd3, 1'b0, 1'b0, -1, 2'b00, 1'b0);
        wait_grant(1'b1);
        wait_done();
        expect_txn(1'b0, 32'h0001_3000, 8'd7, 1'b0, 1'b0, -1, 2'b00, 1'b0);
        issue(1'b0, 4'd4, 8'd7, 1'b0);
        issue(1'b1, 4'd5, 8'd7, 1'b0);
        wait_grant(1'b0);
        wait_done();
        expect_txn(1'b1, 32'h0001_3C00, 8'd7, 1'b0, 1'b0, -1, 2'b00, 1'b0);
        wait_grant(1'b1);
        wait_done();

        // Client read-ready toggling every cycle.
        expect_txn(1'b1, 32'h0001_4800, 8'd15, 1'b0, 1'b1, -1, 2'b00, 1'b0);
        issue(1'b1, 4'd6, 8'd15, 1'b0);
        wait_grant(1'b1);
        wait_done();

        // Error on B, then error on R beat 5, then a clean single-beat read.
        expect_txn(1'b1, 32'h0001_1800, 8'd15, 1'b1, 1'b0, -1, 2'b10, 1'b1);
        issue(1'b1, 4'd2, 8'd15, 1'b1);
        wait_grant(1'b1);
        wait_done();
        expect_txn(1'b0, 32'h0001_5400, 8'd15, 1'b0, 1'b0, 5, 2'b00, 1'b1);
        issue(1'b0, 4'd7, 8'd15, 1'b0);
        wait_grant(1'b0);
        wait_done();
        expect_txn(1'b1, 32'h0001_0000, 8'd0, 1'b0, 1'b0, -1, 2'b00, 1'b0);
        issue(1'b1, 4'd0, 8'd0, 1'b0);
        wait_grant(1'b1);
        wait_done();

        // Reset while read beat 40 of a write-back transaction is in flight.
        expect_txn(1'b0, 32'h0001_3C00, 8'd63, 1'b1, 1'b0, -1, 2'b00, 1'b0);
        issue(1'b0, 4'd5, 8'd63, 1'b1);
        wait_grant(1'b0);
        begin
            bit got = 0;
            for (int i = 0; i < 300 && !got; i++) begin
                @(negedge clk);
                if (rd_cnt >= 40) got = 1;
            end
            if (!got) begin
                total++; bad++;
                $display("FAIL beat40_timeout: got %0d beats, expected 40", rd_cnt);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_arvalid", arvalid, 1'b0);
        chk("arst_awvalid", awvalid, 1'b0);
        chk("arst_wvalid", wvalid, 1'b0);
        chk("arst_rready", rready, 1'b0);
        chk("arst_busy", busy, 1'b0);
        exp_q.delete();
        n_want--;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        expect_txn(1'b1, 32'h0001_4800, 8'd3, 1'b0, 1'b0, -1, 2'b00, 1'b0);
        issue(1'b1, 4'd6, 8'd3, 1'b0);
        wait_grant(1'b1);
        wait_done();

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000 ns");
        $fatal(1);
    end

endmodule
